// File: rtl/sx_pkg.sv
// Shared definitions for the send-FIFO write path: channel lanes, parser states
// and the default framing constants.
package sx_pkg;

    localparam logic [1:0] CH_FIX_CTRL = 2'd0;
    localparam logic [1:0] CH_CTRL     = 2'd1;
    localparam logic [1:0] CH_BUSI     = 2'd2;
    localparam logic [1:0] CH_CIRCUIT  = 2'd3;

    localparam logic [7:0] SYNC_H_DEF  = 8'hEB;
    localparam logic [7:0] SYNC_L_DEF  = 8'h90;
    localparam int         MAX_LEN_DEF = 320;
    localparam int         TIMEOUT_DEF = 16384;

    typedef enum logic [2:0] {
        HUNT_H,
        HUNT_L,
        GET_CH,
        GET_LH,
        GET_LL,
        PAYLOAD,
        CHECK
    } parse_state_t;

endpackage

// File: rtl/sx_sat_cnt16.sv
// 16-bit statistics counter: synchronous clear wins over increment, and the
// count sticks at all-ones instead of wrapping.
module sx_sat_cnt16 (
    input  logic        sys_clk_i,
    input  logic        rst_n_i,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            cnt <= 16'h0000;
        end else if (clr) begin
            cnt <= 16'h0000;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/sx_send_fifo_wr.sv
// Frame parser feeding the four per-channel send FIFOs: steers payload bytes
// onto lane ch of the shared write bus and keeps per-channel statistics.
module sx_send_fifo_wr
    import sx_pkg::*;
#(
    parameter int         MAX_LEN = MAX_LEN_DEF,
    parameter int         TIMEOUT = TIMEOUT_DEF,
    parameter logic [7:0] SYNC_H  = SYNC_H_DEF,
    parameter logic [7:0] SYNC_L  = SYNC_L_DEF
) (
    input  logic        sys_clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  up_data_i,
    input  logic        up_valid_i,
    output logic [3:0]  send_fifo_wr_en,
    output logic [31:0] send_fifo_wr_data,
    input  logic [3:0]  send_fifo_full,
    output logic [63:0] frame_ok_cnt,
    output logic [63:0] drop_byte_cnt,
    output logic [15:0] err_cnt,
    output logic [3:0]  overflow_flag,
    input  logic        clr_stat_i
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    parse_state_t     state;
    logic [1:0]       ch;
    logic [7:0]       len_hi;
    logic [15:0]      remaining;
    logic [7:0]       xor_acc;
    logic [TMO_W-1:0] tmo_cnt;

    logic [15:0] len_full;
    logic [3:0]  lane_sel;
    logic        timeout_hit;
    logic        err_inc;
    logic [3:0]  ok_inc;
    logic [3:0]  drop_inc;

    // A valid byte in the expiry cycle keeps the frame alive, so expiry
    // only ever happens on an idle cycle.
    always_comb begin
        len_full    = {len_hi, up_data_i};
        lane_sel    = 4'b0001 << ch;
        timeout_hit = (state != HUNT_H) && !up_valid_i &&
                      (tmo_cnt == TMO_W'(TIMEOUT - 1));
        err_inc     = timeout_hit;
        ok_inc      = 4'b0000;
        drop_inc    = 4'b0000;
        if (up_valid_i) begin
            case (state)
                GET_CH:  err_inc = (up_data_i[7:2] != 6'd0);
                GET_LL:  err_inc = (len_full == 16'd0) || (len_full > 16'(MAX_LEN));
                PAYLOAD: drop_inc = lane_sel & send_fifo_full;
                CHECK: begin
                    if (up_data_i == xor_acc) begin
                        ok_inc = lane_sel;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            state             <= HUNT_H;
            ch                <= 2'd0;
            len_hi            <= 8'h00;
            remaining         <= 16'h0000;
            xor_acc           <= 8'h00;
            tmo_cnt           <= '0;
            send_fifo_wr_en   <= 4'b0000;
            send_fifo_wr_data <= 32'h0000_0000;
            overflow_flag     <= 4'b0000;
        end else begin
            send_fifo_wr_en <= 4'b0000;
            overflow_flag   <= clr_stat_i ? 4'b0000 : (overflow_flag | drop_inc);

            if (up_valid_i || state == HUNT_H || timeout_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (timeout_hit) begin
                state <= HUNT_H;
            end else if (up_valid_i) begin
                case (state)
                    HUNT_H: begin
                        if (up_data_i == SYNC_H) state <= HUNT_L;
                    end
                    HUNT_L: begin
                        if (up_data_i == SYNC_L) begin
                            state <= GET_CH;
                        end else if (up_data_i != SYNC_H) begin
                            state <= HUNT_H;
                        end
                    end
                    GET_CH: begin
                        if (up_data_i[7:2] != 6'd0) begin
                            state <= HUNT_H;
                        end else begin
                            ch      <= up_data_i[1:0];
                            xor_acc <= up_data_i;
                            state   <= GET_LH;
                        end
                    end
                    GET_LH: begin
                        len_hi  <= up_data_i;
                        xor_acc <= xor_acc ^ up_data_i;
                        state   <= GET_LL;
                    end
                    GET_LL: begin
                        remaining <= len_full;
                        xor_acc   <= xor_acc ^ up_data_i;
                        if ((len_full == 16'd0) || (len_full > 16'(MAX_LEN))) begin
                            state <= HUNT_H;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        xor_acc           <= xor_acc ^ up_data_i;
                        remaining         <= remaining - 16'd1;
                        send_fifo_wr_en   <= lane_sel & ~send_fifo_full;
                        send_fifo_wr_data <= {4{up_data_i}};
                        if (remaining == 16'd1) state <= CHECK;
                    end
                    CHECK:   state <= HUNT_H;
                    default: state <= HUNT_H;
                endcase
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane_cnt
        sx_sat_cnt16 u_ok_cnt (
            .sys_clk_i (sys_clk_i),
            .rst_n_i   (rst_n_i),
            .clr       (clr_stat_i),
            .inc       (ok_inc[i]),
            .cnt       (frame_ok_cnt[16*i +: 16])
        );
        sx_sat_cnt16 u_drop_cnt (
            .sys_clk_i (sys_clk_i),
            .rst_n_i   (rst_n_i),
            .clr       (clr_stat_i),
            .inc       (drop_inc[i]),
            .cnt       (drop_byte_cnt[16*i +: 16])
        );
    end

    sx_sat_cnt16 u_err_cnt (
        .sys_clk_i (sys_clk_i),
        .rst_n_i   (rst_n_i),
        .clr       (clr_stat_i),
        .inc       (err_inc),
        .cnt       (err_cnt)
    );

endmodule
